// File: rtl/amplitude_ramp_mc.sv
`timescale 1ns/1ps
// amplitude_ramp_mc
//   Applies one switch-selected gain to CH parallel signed PCM lanes. The
//   applied gain slews toward the selected target by RAMP_STEP once per
//   accepted frame, so that gain changes do not cause zipper noise or pops.
//   Each product is rounded half up and saturated back to W bits.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   control    3-bit gain select from switches (asynchronous to clk)
//   in_valid   audio_in holds a frame this cycle
//   audio_in   CH lanes, lane c at [c*W +: W], signed
//   out_valid  audio_out holds a new frame this cycle (in_valid delayed 2)
//   audio_out  scaled, rounded and saturated lanes, same packing
//   gain_cur   gain currently applied, unsigned Q3.GQ
//   ramping    high while the gain is still moving toward its target
module amplitude_ramp_mc #(
  parameter int          W         = 16,
  parameter int          CH        = 2,
  parameter int          GQ        = 14,
  parameter int unsigned RAMP_STEP = 'h0080
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        control,
  input  logic              in_valid,
  input  logic [CH*W-1:0]   audio_in,
  output logic              out_valid,
  output logic [CH*W-1:0]   audio_out,
  output logic [GQ+2:0]     gain_cur,
  output logic              ramping
);

  localparam int GW = GQ + 3;
  localparam int PW = W + GW;

  localparam logic [GW-1:0] STEP = GW'(RAMP_STEP);

  // Gain table. The sqrt(2) entries are 14-bit fraction constants
  // rescaled to whatever GQ this build uses.
  localparam logic [GW-1:0] G_EIGHTH  = GW'(64'd1 << (GQ - 3));
  localparam logic [GW-1:0] G_QUARTER = GW'(64'd1 << (GQ - 2));
  localparam logic [GW-1:0] G_HALF    = GW'(64'd1 << (GQ - 1));
  localparam logic [GW-1:0] G_RSQRT2  = GW'((64'h2D41 << GQ) >> 14);
  localparam logic [GW-1:0] G_ONE     = GW'(64'd1 << GQ);
  localparam logic [GW-1:0] G_SQRT2   = GW'((64'h5A82 << GQ) >> 14);
  localparam logic [GW-1:0] G_TWO     = GW'(64'd1 << (GQ + 1));

  localparam logic signed [PW:0] RND     = {{(PW + 1 - GQ){1'b0}}, 1'b1, {(GQ - 1){1'b0}}};
  localparam logic signed [PW:0] SAT_MAX = {{(GW + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [PW:0] SAT_MIN = {{(GW + 2){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {MUTED, RAMP_UP, RAMP_DOWN, STEADY} state_t;

  logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [GW-1:0]   gain_q, gain_d;
  state_t          state_q, state_d;
  logic            valid1_q, valid1_d, valid2_q, valid2_d;
  logic [PW-1:0]   prod_q [CH];
  logic [PW-1:0]   prod_d [CH];
  logic [CH*W-1:0] audio_out_q, audio_out_d;

  logic [GW-1:0]   target;
  logic [GW:0]     up_sum;
  logic [GW-1:0]   down_gap;
  logic [PW-1:0]   lane_ext [CH];
  logic [PW-1:0]   gain_ext;
  logic signed [PW:0] rsum    [CH];
  logic signed [PW:0] shifted [CH];

  // Two-flop synchronizer for the switches; the table reads only the
  // second stage.
  always_comb begin
    sync1_d = control;
    sync2_d = sync1_q;
    target  = '0;
    case (sync2_q)
      3'b000:  target = '0;
      3'b001:  target = G_EIGHTH;
      3'b010:  target = G_QUARTER;
      3'b011:  target = G_HALF;
      3'b100:  target = G_RSQRT2;
      3'b101:  target = G_ONE;
      3'b110:  target = G_SQRT2;
      3'b111:  target = G_TWO;
      default: target = '0;
    endcase
  end

  // Gain slew and FSM next state. The gain only moves on frame cycles and
  // clamps at the target so it never overshoots; the direction is chosen
  // afresh on every frame, so a target change mid-ramp simply reverses it.
  always_comb begin
    up_sum   = {1'b0, gain_q} + {1'b0, STEP};
    down_gap = gain_q - target;
    gain_d   = gain_q;
    state_d  = state_q;
    if (in_valid) begin
      if (gain_q < target) begin
        gain_d = (up_sum >= {1'b0, target}) ? target : up_sum[GW-1:0];
      end else if (gain_q > target) begin
        gain_d = (down_gap <= STEP) ? target : (gain_q - STEP);
      end
    end
    if (gain_d == target) begin
      state_d = (gain_d == '0) ? MUTED : STEADY;
    end else if (gain_d < target) begin
      state_d = RAMP_UP;
    end else begin
      state_d = RAMP_DOWN;
    end
  end

  // Stage 1: every lane of a frame is multiplied by the gain in force
  // before this frame's ramp update. Both operands are widened to the
  // product width; the gain is zero-extended so it acts as a positive value.
  always_comb begin
    valid1_d = in_valid;
    gain_ext = {{W{1'b0}}, gain_q};
    for (int c = 0; c < CH; c++) begin
      lane_ext[c] = {{GW{audio_in[c*W + W - 1]}}, audio_in[c*W +: W]};
      prod_d[c]   = lane_ext[c] * gain_ext;
    end
  end

  // Stage 2: round half up, drop the fraction bits, then clamp to the
  // signed W-bit range. The output register holds across bubbles.
  always_comb begin
    valid2_d    = valid1_q;
    audio_out_d = audio_out_q;
    for (int c = 0; c < CH; c++) begin
      rsum[c]    = $signed({prod_q[c][PW-1], prod_q[c]}) + RND;
      shifted[c] = rsum[c] >>> GQ;
      if (valid1_q) begin
        if (shifted[c] > SAT_MAX) begin
          audio_out_d[c*W +: W] = {1'b0, {(W - 1){1'b1}}};
        end else if (shifted[c] < SAT_MIN) begin
          audio_out_d[c*W +: W] = {1'b1, {(W - 1){1'b0}}};
        end else begin
          audio_out_d[c*W +: W] = shifted[c][W-1:0];
        end
      end
    end
  end

  // State registers. Reset drops any frames already in the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      gain_q      <= '0;
      state_q     <= MUTED;
      valid1_q    <= 1'b0;
      valid2_q    <= 1'b0;
      audio_out_q <= '0;
      for (int c = 0; c < CH; c++) begin
        prod_q[c] <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      gain_q      <= gain_d;
      state_q     <= state_d;
      valid1_q    <= valid1_d;
      valid2_q    <= valid2_d;
      audio_out_q <= audio_out_d;
      for (int c = 0; c < CH; c++) begin
        prod_q[c] <= prod_d[c];
      end
    end
  end

  assign out_valid = valid2_q;
  assign audio_out = audio_out_q;
  assign gain_cur  = gain_q;
  assign ramping   = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

endmodule
